// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Wait counter width; a zero-latency build still needs a 1-bit counter.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: asynchronous read,
// synchronous write, whole array cleared by the asynchronous reset.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder with configurable access latency and stall.
// Optional posted stores: define DMEM_RESP_POSTED_WRITE_EN.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err
);
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              req;
    logic              conflict;
    logic              unused_addr_bits;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [ADDR_W-1:0] arr_raddr;
    logic [DATA_W-1:0] arr_rdata;

    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign word_idx         = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^addr[31:ADDR_W+2];
    assign misaligned       = |(addr[1:0] & WORD_ALIGN_MASK);
    assign req              = mem_read | mem_write;
    assign conflict         = mem_read & mem_write;

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    generate
        if (LATENCY == 0) begin : g_comb
            assign arr_raddr = word_idx;
            assign arr_waddr = word_idx;
            assign arr_wdata = wdata;
            assign arr_we    = mem_write & ~misaligned & ~reset;
            assign stall     = 1'b0;
            assign err       = req & (misaligned | conflict) & ~reset;
            assign rdata     = (mem_read & ~mem_write & ~misaligned) ? arr_rdata : '0;
        end else begin : g_fsm
            localparam int CNT_W = cnt_width(LATENCY);
            localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

            state_t            state_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic              write_reg;
            logic              mis_reg;
            logic              err_reg;
            logic [ADDR_W-1:0] idx_reg;
            logic [DATA_W-1:0] wdata_reg;
            logic [DATA_W-1:0] rdata_reg;
            logic              posted_store;
            logic              commit_wait;
            logic              stall_next;

`ifdef DMEM_RESP_POSTED_WRITE_EN
            assign posted_store = (state_reg == IDLE) && mem_write;
            assign arr_we = commit_wait || ((state_reg == DRAIN) && (cnt_reg == '0));
`else
            assign posted_store = 1'b0;
            assign arr_we = commit_wait;
`endif
            assign commit_wait = (state_reg == WAIT) && (cnt_reg == '0) && write_reg && !mis_reg;
            assign arr_raddr   = idx_reg;
            assign arr_waddr   = idx_reg;
            assign arr_wdata   = wdata_reg;

            always_comb begin
                stall_next = 1'b0;
                case (state_reg)
                    IDLE:    stall_next = req & ~posted_store;
                    WAIT:    stall_next = 1'b1;
                    DRAIN:   stall_next = req;
                    default: stall_next = 1'b0;
                endcase
            end

            assign stall = stall_next & ~reset;
            assign err   = (((state_reg == DONE) & err_reg)
                           | (posted_store & (misaligned | mem_read))) & ~reset;
            assign rdata = rdata_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    write_reg <= 1'b0;
                    mis_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    idx_reg   <= '0;
                    wdata_reg <= '0;
                    rdata_reg <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
`ifdef DMEM_RESP_POSTED_WRITE_EN
                            if (posted_store) begin
                                // A misaligned posted store is dropped; err already pulsed.
                                if (!misaligned) begin
                                    idx_reg   <= word_idx;
                                    wdata_reg <= wdata;
                                    cnt_reg   <= CNT_INIT;
                                    state_reg <= DRAIN;
                                end
                            end else
`endif
                            if (req) begin
                                write_reg <= mem_write;
                                mis_reg   <= misaligned;
                                err_reg   <= misaligned | conflict;
                                idx_reg   <= word_idx;
                                wdata_reg <= wdata;
                                cnt_reg   <= CNT_INIT;
                                state_reg <= WAIT;
                            end
                        end
                        WAIT: begin
                            if (cnt_reg != '0) begin
                                cnt_reg <= cnt_reg - 1'b1;
                            end else begin
                                if (!write_reg) begin
                                    rdata_reg <= mis_reg ? '0 : arr_rdata;
                                end
                                state_reg <= DONE;
                            end
                        end
                        DONE: state_reg <= IDLE;
`ifdef DMEM_RESP_POSTED_WRITE_EN
                        DRAIN: begin
                            if (cnt_reg != '0) begin
                                cnt_reg <= cnt_reg - 1'b1;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
`endif
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a latency DUT and a zero-latency DUT.
module tb_dmem_responder;

`ifdef DMEM_RESP_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
    localparam int LAT    = 3;
`else
    localparam bit POSTED = 1'b0;
    localparam int LAT    = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        a_rd = 0, a_wr = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
    logic        a_stall, a_err;

    logic        z_rd = 0, z_wr = 0;
    logic [31:0] z_addr = 0, z_wdata = 0, z_rdata;
    logic        z_stall, z_err;

    dmem_responder #(.LATENCY(LAT), .ADDR_W(8), .DATA_W(32)) u_dut (
        .clock(clock), .reset(reset), .mem_read(a_rd), .mem_write(a_wr),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .stall(a_stall), .err(a_err)
    );

    dmem_responder #(.LATENCY(0), .ADDR_W(8), .DATA_W(32)) u_dut_zero (
        .clock(clock), .reset(reset), .mem_read(z_rd), .mem_write(z_wr),
        .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata), .stall(z_stall), .err(z_err)
    );

    typedef struct {
        string       tag;
        bit          is_read;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stalls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_a [256];
    logic [31:0] model_z [256];
    bit          pending_drain = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_z[i] = '0;
        end
        pending_drain = 1'b0;
    endtask

    // Called at posedge+1; leaves time at posedge+1 with the request removed.
    task automatic a_access(input string tag, input bit rd, input bit wr,
                            input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        exp_t got_e;
        int   stalls;
        bit   done;
        bit   mis;
        int   idx;
        mis = (ad[1:0] != 2'b00);
        idx = int'(ad[9:2]);
        e.tag        = tag;
        e.is_read    = rd && !wr;
        e.exp_err    = mis || (rd && wr);
        e.exp_rdata  = mis ? 32'h0 : model_a[idx];
        e.exp_stalls = (POSTED && wr) ? 0 : LAT + 1;
        if (pending_drain) e.exp_stalls += LAT;
        pending_drain = POSTED && wr && !mis;
        if (wr && !mis) model_a[idx] = wd;
        sb.push_back(e);

        a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clock);
            if (a_stall) stalls++;
            else done = 1'b1;
        end
        got_e = sb.pop_front();
        $display("[%0t] %s rd=%0b wr=%0b addr=0x%08h wdata=0x%08h stalls=%0d rdata=0x%08h err=%0b",
                 $time, got_e.tag, rd, wr, ad, wd, stalls, a_rdata, a_err);
        check_eq({got_e.tag, "_complete"}, 32'(done), 32'd1);
        check_eq({got_e.tag, "_stalls"}, 32'(stalls), 32'(got_e.exp_stalls));
        check_eq({got_e.tag, "_err"}, 32'(a_err), 32'(got_e.exp_err));
        if (got_e.is_read) check_eq({got_e.tag, "_rdata"}, a_rdata, got_e.exp_rdata);
        @(posedge clock);
        #1;
        a_rd = 1'b0;
        a_wr = 1'b0;
    endtask

    task automatic z_access(input string tag, input bit rd, input bit wr,
                            input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        exp_t got_e;
        bit   mis;
        int   idx;
        mis = (ad[1:0] != 2'b00);
        idx = int'(ad[9:2]);
        e.tag        = tag;
        e.is_read    = rd && !wr;
        e.exp_err    = mis || (rd && wr);
        e.exp_rdata  = mis ? 32'h0 : model_z[idx];
        e.exp_stalls = 0;
        if (wr && !mis) model_z[idx] = wd;
        sb.push_back(e);

        z_rd = rd; z_wr = wr; z_addr = ad; z_wdata = wd;
        @(negedge clock);
        got_e = sb.pop_front();
        $display("[%0t] %s rd=%0b wr=%0b addr=0x%08h wdata=0x%08h stall=%0b rdata=0x%08h err=%0b",
                 $time, got_e.tag, rd, wr, ad, wd, z_stall, z_rdata, z_err);
        check_eq({got_e.tag, "_stall"}, 32'(z_stall), 32'(got_e.exp_stalls));
        check_eq({got_e.tag, "_err"}, 32'(z_err), 32'(got_e.exp_err));
        if (got_e.is_read) check_eq({got_e.tag, "_rdata"}, z_rdata, got_e.exp_rdata);
        @(posedge clock);
        #1;
        z_rd = 1'b0;
        z_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
        if (n >= LAT) pending_drain = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd_addr;
        logic [31:0] rnd_data;
        clear_models();

        @(negedge clock);
        check_eq("reset_stall", 32'(a_stall), 32'd0);
        check_eq("reset_err", 32'(a_err), 32'd0);
        check_eq("reset_rdata", a_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        a_access("mis_wr13", 1'b0, 1'b1, 32'h13, 32'hCAFE_F00D);
        a_access("rd10_prior", 1'b1, 1'b0, 32'h10, 32'h0);
        a_access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        a_access("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
        a_access("wr00", 1'b0, 1'b1, 32'h0, 32'h55);
        a_access("rd400_wrap", 1'b1, 1'b0, 32'h400, 32'h0);
        a_access("conflict04", 1'b1, 1'b1, 32'h4, 32'h99);
        a_access("rd04", 1'b1, 1'b0, 32'h4, 32'h0);
        a_access("mis_rd11", 1'b1, 1'b0, 32'h11, 32'h0);
        a_access("wr20", 1'b0, 1'b1, 32'h20, 32'h77);
        a_access("rd20", 1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rnd_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            rnd_data = $urandom;
            a_access("rnd_wr", 1'b0, 1'b1, rnd_addr, rnd_data);
            a_access("rnd_rd", 1'b1, 1'b0, rnd_addr, 32'h0);
        end

        idle(LAT);
        z_access("z_wr10", 1'b0, 1'b1, 32'h10, 32'h1234);
        z_access("z_rd10", 1'b1, 1'b0, 32'h10, 32'h0);
        z_access("z_mis_rd12", 1'b1, 1'b0, 32'h12, 32'h0);
        z_access("z_conflict20", 1'b1, 1'b1, 32'h20, 32'h5A5A);
        z_access("z_rd420_wrap", 1'b1, 1'b0, 32'h420, 32'h0);

        // Abort a write of 0xAA to 0x8 with reset in its second wait cycle.
        a_access("pre_rd04", 1'b1, 1'b0, 32'h4, 32'h0);
        idle(LAT + 1);
        a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h8; a_wdata = 32'hAA;
        @(posedge clock);
        #1;
        if (POSTED) a_wr = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        a_wr  = 1'b0;
        #1;
        check_eq("abort_stall", 32'(a_stall), 32'd0);
        check_eq("abort_err", 32'(a_err), 32'd0);
        check_eq("abort_rdata", a_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_models();
        a_access("rd08_after_abort", 1'b1, 1'b0, 32'h8, 32'h0);
        z_access("z_rd10_after_reset", 1'b1, 1'b0, 32'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data port, replacing the zero-latency data memory model.
- Services word loads and stores with a configurable access latency.
- Drives a stall back to the hazard logic so the pipeline freezes PC, IF/ID and later stages until the access completes.
- Sits in the MEM stage, driven by the EX/MEM register outputs.

Parameters:
- LATENCY, 2, extra wait cycles per access; 0 means single-cycle completion with no stall.
- ADDR_W, 8, word-index width; memory depth is 2**ADDR_W words.
- DATA_W, 32, data word width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request; level, held by the CPU while stall=1.
- mem_write  in  1  store request; level, held while stall=1.
- addr  in  32  byte address (ALU result).
- wdata  in  DATA_W  store data (forwarded rt).
- rdata  out  DATA_W  load data; valid in the cycle stall drops for a read.
- stall  out  1  high while an accepted access is incomplete; combinational from state and request.
- err  out  1  one-cycle pulse on a misaligned access or read+write conflict.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, counter=0, rdata=0, err=0, stall=0.
  - Latched op, address and data cleared; memory array cleared to 0.
  - Reset during WAIT aborts the access; a pending write is not performed.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; upper bits ignored, so addresses wrap modulo depth.
  - addr[1:0]!=0 is misaligned: err pulses on completion, the write is suppressed, rdata=0.
- Conflict: mem_read and mem_write both high means the write wins and err pulses on completion.
- LATENCY=0:
  - Never stalls.
  - Reads are combinational from the array.
  - Writes commit at the clock edge ending the request cycle.
  - err is combinational in that cycle.
- LATENCY>0, states IDLE, WAIT, DONE:
  - IDLE:
    - No request: stall=0.
    - Request present: stall=1 combinationally; latch op, word index and wdata; counter=LATENCY-1; go to WAIT.
  - WAIT:
    - stall=1.
    - counter!=0: decrement.
    - counter==0: perform the write, or capture array data into the rdata register for a read; go to DONE.
  - DONE:
    - stall=0; rdata holds the result; err pulses here if flagged; go to IDLE.
    - The pipeline advances at the end of DONE. The request still visible in DONE is the completed one and is ignored.
- Total access: LATENCY+1 stall cycles, then one DONE cycle.
- Back-to-back requests: a new request arriving in the cycle after DONE is accepted normally.
- Request inputs are ignored in WAIT and DONE; the latched copy is used.
- Counter width: $clog2(LATENCY+1), minimum 1.
- rdata holds its last value outside DONE; it updates only on read completion.

Optional Feature:
- Macro: DMEM_RESP_POSTED_WRITE_EN.
- When defined:
  - A store in IDLE completes with stall=0 in its request cycle and is copied into a 1-entry write buffer.
  - The FSM enters DRAIN for LATENCY cycles, then commits the buffer to the array and returns to IDLE.
  - Any request arriving during DRAIN stalls until the drain commits, then is processed normally from IDLE; there is no read bypass.
  - Misaligned posted writes pulse err in the request cycle and are not buffered.
- When undefined: stores behave exactly as loads (IDLE/WAIT/DONE) and the DRAIN state does not exist.

Decomposition:
- Package dmem_resp_pkg holds:
  - state enum (IDLE, WAIT, DONE, DRAIN);
  - WORD_ALIGN_MASK=2'b11;
  - the counter-width function.
- Sub-module dmem_array: DATA_W x 2**ADDR_W storage with asynchronous read, synchronous write enable and asynchronous clear. The FSM lives in dmem_responder.

Test Plan:
- LATENCY=2, write 0xDEADBEEF to 0x10, hold until stall=0, then read 0x10 -> stall high 3 cycles each, rdata=0xDEADBEEF in the DONE cycle, err=0.
- LATENCY=0, read 0x10 after a write of 0x1234 -> stall never asserted, rdata=0x1234 in the same cycle.
- Write to 0x13 (misaligned) then read 0x10 -> err pulses once on completion, read returns the prior value 0.
- Write 0x55 to 0x0 then read 0x400 with ADDR_W=8 -> wraps to word 0, rdata=0x55.
- Assert reset in the second WAIT cycle of a write of 0xAA to 0x8 -> stall=0 immediately, later read of 0x8 returns 0.
- With DMEM_RESP_POSTED_WRITE_EN and LATENCY=3: write 0x77 to 0x20 then read 0x20 next cycle -> write has stall=0; read stalls through drain plus access; rdata=0x77.
